hub75_bcm_driver: RTL and testbench

HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

---
 rtl/hub75_bcm_driver.sv | 204 ++++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: drives a HUB75 LED panel from column beats using
// binary-coded modulation. Each accepted column is shifted out once per
// colour bit-plane, latched, then displayed for BASE_PERIOD << plane cycles.
// Optional feature: define HUB75_DOUBLE_BUFFER_EN to add a shadow column
// register so the next beat can be taken while the current one is displayed.
module hub75_bcm_driver #(
  parameter int NUM_ROWS    = 64,
  parameter int NUM_CHAINS  = 2,
  parameter int COLOR_BITS  = 3,
  parameter int BASE_PERIOD = 100,
  parameter int SCAN_RATE   = 32,
  localparam int ADDR_W     = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic [NUM_CHAINS-1:0][NUM_ROWS-1:0][3*COLOR_BITS-1:0]  column_data,
  input  logic [ADDR_W-1:0]                                      col_index,
  input  logic                                                   tvalid,
  output logic                                                   tready,
  output logic [NUM_CHAINS-1:0][2:0]                             rgb,
  output logic                                                   led_clk,
  output logic                                                   led_latch,
  output logic                                                   led_output_enable,
  output logic [ADDR_W-1:0]                                      row_addr
);

  localparam int PIX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PLANE_W  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int BIT_W    = $clog2(3 * COLOR_BITS);
  localparam int HOLD_MAX = BASE_PERIOD << (COLOR_BITS - 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(NUM_ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOR_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef logic [NUM_CHAINS-1:0][NUM_ROWS-1:0][3*COLOR_BITS-1:0] column_t;
  typedef logic [NUM_CHAINS-1:0][2:0]                             rgb_t;

  logic [1:0]         state;
  logic [PLANE_W-1:0] plane;
  logic [PIX_W-1:0]   pixel;
  logic               phase;
  logic [HOLD_W-1:0]  hold_cnt;
  column_t            active_data;
  logic [ADDR_W-1:0]  active_idx;

  logic               accept;
  logic               column_end;
  logic               start_now;
  column_t            start_data;
  logic [ADDR_W-1:0]  start_idx;

`ifdef HUB75_DOUBLE_BUFFER_EN
  column_t            shadow_data;
  logic [ADDR_W-1:0]  shadow_idx;
  logic               shadow_valid;
`endif

  // Picks bit `pl` of R, G and B for pixel `pix` on every chain.
  function automatic rgb_t plane_bits(input column_t col,
                                      input logic [PIX_W-1:0] pix,
                                      input logic [PLANE_W-1:0] pl);
    rgb_t             bits;
    logic [BIT_W-1:0] r_i;
    logic [BIT_W-1:0] g_i;
    logic [BIT_W-1:0] b_i;
    r_i  = BIT_W'(pl);
    g_i  = BIT_W'(COLOR_BITS + int'(pl));
    b_i  = BIT_W'(2 * COLOR_BITS + int'(pl));
    bits = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      bits[c][0] = col[c][pix][r_i];
      bits[c][1] = col[c][pix][g_i];
      bits[c][2] = col[c][pix][b_i];
    end
    return bits;
  endfunction

  // Handshake and column-start decision; tready is the only unregistered output.
  always_comb begin
    tready     = 1'b0;
    start_now  = 1'b0;
    start_data = column_data;
    start_idx  = col_index;
    column_end = (state == ST_HOLD) && (hold_cnt == '0) && (plane == LAST_PLANE);
`ifdef HUB75_DOUBLE_BUFFER_EN
    tready = !rst_in && !shadow_valid;
`else
    tready = !rst_in && (state == ST_IDLE);
`endif
    accept = tvalid && tready;
    if ((state == ST_IDLE) && accept) begin
      start_now = 1'b1;
    end
`ifdef HUB75_DOUBLE_BUFFER_EN
    if (column_end) begin
      if (shadow_valid) begin
        start_now  = 1'b1;
        start_data = shadow_data;
        start_idx  = shadow_idx;
      end else if (accept) begin
        start_now = 1'b1;
      end
    end
`endif
  end

`ifdef HUB75_DOUBLE_BUFFER_EN
  // Shadow register parks a beat that arrives while a column is still on display.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_data  <= '0;
      shadow_idx   <= '0;
      shadow_valid <= 1'b0;
    end else if (accept && (state != ST_IDLE) && !column_end) begin
      shadow_data  <= column_data;
      shadow_idx   <= col_index;
      shadow_valid <= 1'b1;
    end else if (column_end && shadow_valid) begin
      shadow_valid <= 1'b0;
    end
  end
`endif

  // Sequencer: panel outputs are registered together with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      plane             <= '0;
      pixel             <= '0;
      phase             <= 1'b0;
      hold_cnt          <= '0;
      active_data       <= '0;
      active_idx        <= '0;
      rgb               <= '0;
      led_clk           <= 1'b0;
      led_latch         <= 1'b0;
      led_output_enable <= 1'b1;
      row_addr          <= '0;
    end else if (start_now) begin
      active_data       <= start_data;
      active_idx        <= start_idx;
      plane             <= '0;
      pixel             <= '0;
      phase             <= 1'b0;
      hold_cnt          <= '0;
      state             <= ST_SHIFT;
      rgb               <= plane_bits(start_data, PIX_W'(0), PLANE_W'(0));
      led_clk           <= 1'b0;
      led_latch         <= 1'b0;
      led_output_enable <= 1'b1;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (!phase) begin
            led_clk <= 1'b1;
            phase   <= 1'b1;
          end else if (pixel == LAST_PIX) begin
            state     <= ST_LATCH;
            phase     <= 1'b0;
            led_clk   <= 1'b0;
            led_latch <= 1'b1;
            row_addr  <= active_idx;
          end else begin
            pixel   <= pixel + PIX_W'(1);
            phase   <= 1'b0;
            led_clk <= 1'b0;
            rgb     <= plane_bits(active_data, pixel + PIX_W'(1), plane);
          end
        end
        ST_LATCH: begin
          state             <= ST_HOLD;
          led_latch         <= 1'b0;
          led_output_enable <= 1'b0;
          hold_cnt          <= HOLD_W'((BASE_PERIOD << plane) - 1);
        end
        ST_HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (plane != LAST_PLANE) begin
            plane             <= plane + PLANE_W'(1);
            pixel             <= '0;
            phase             <= 1'b0;
            state             <= ST_SHIFT;
            led_output_enable <= 1'b1;
            rgb               <= plane_bits(active_data, PIX_W'(0), plane + PLANE_W'(1));
          end else begin
            state             <= ST_IDLE;
            led_output_enable <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Testbench for hub75_bcm_driver. Accepted beats push the expected shift
// words, latch addresses and hold lengths into queues; a monitor on the
// falling clock edge pops and compares them as the panel outputs appear.
// Builds with or without HUB75_DOUBLE_BUFFER_EN.
module tb_hub75_bcm_driver;

  localparam int NR = 64;
  localparam int NC = 2;
  localparam int CB = 3;
  localparam int BP = 100;
  localparam int SR = 32;
  localparam int AW = $clog2(SR);
  localparam int COL_CYCLES = CB * (2 * NR + 1) + BP * ((1 << CB) - 1);
`ifdef HUB75_DOUBLE_BUFFER_EN
  localparam bit DOUBLE_BUF = 1'b1;
`else
  localparam bit DOUBLE_BUF = 1'b0;
`endif

  typedef logic [NC-1:0][NR-1:0][3*CB-1:0] col_t;
  typedef logic [NC-1:0][2:0]              rgb_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  col_t          column_data;
  logic [AW-1:0] col_index;
  logic          tvalid;
  logic          tready;
  rgb_t          rgb;
  logic          led_clk;
  logic          led_latch;
  logic          led_output_enable;
  logic [AW-1:0] row_addr;

  int   total = 0;
  int   bad   = 0;
  rgb_t exp_shift[$];
  int   exp_latch[$];
  int   exp_hold[$];
  int   model_rem    = 0;
  bit   model_shadow = 1'b0;

  logic mon_prev_clk = 1'b0;
  int   mon_shifts   = 0;
  int   mon_hold_run = 0;
  rgb_t mon_exp;

  hub75_bcm_driver #(
    .NUM_ROWS(NR), .NUM_CHAINS(NC), .COLOR_BITS(CB),
    .BASE_PERIOD(BP), .SCAN_RATE(SR)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .column_data(column_data),
    .col_index(col_index), .tvalid(tvalid), .tready(tready), .rgb(rgb),
    .led_clk(led_clk), .led_latch(led_latch),
    .led_output_enable(led_output_enable), .row_addr(row_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic flag_event(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got an event with nothing queued, expected none", name);
  endtask

  // Reference model: what the panel must see for one column, from pixel arithmetic.
  task automatic push_expected(input col_t data, input logic [AW-1:0] idx);
    rgb_t e;
    int   word, r, g, b;
    for (int k = 0; k < CB; k++) begin
      for (int p = 0; p < NR; p++) begin
        e = '0;
        for (int c = 0; c < NC; c++) begin
          word = int'(data[c][p]);
          r = word % (1 << CB);
          g = (word / (1 << CB)) % (1 << CB);
          b = word / (1 << (2 * CB));
          e[c][0] = ((r >> k) & 1) != 0;
          e[c][1] = ((g >> k) & 1) != 0;
          e[c][2] = ((b >> k) & 1) != 0;
        end
        exp_shift.push_back(e);
      end
      exp_latch.push_back(int'(idx));
      exp_hold.push_back(BP * (2 ** k));
    end
  endtask

  function automatic col_t rand_col();
    col_t        d;
    logic [31:0] v;
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NR; p++) begin
        v = $urandom;
        d[c][p] = v[3*CB-1:0];
      end
    end
    return d;
  endfunction

  function automatic logic [AW-1:0] rand_idx();
    logic [31:0] v;
    v = $urandom;
    return v[AW-1:0];
  endfunction

  // One clock cycle of stimulus; tready is checked against the occupancy model.
  task automatic apply_stimulus(input bit valid, input col_t data,
                                input logic [AW-1:0] idx, output bit accepted);
    bit exp_ready;
    tvalid      = valid;
    column_data = data;
    col_index   = idx;
    #1;
    exp_ready = DOUBLE_BUF ? !model_shadow : (model_rem == 0);
    check_output("tready", int'(tready), int'(exp_ready));
    accepted = valid && exp_ready;
    @(posedge clk_in);
    #1;
    if (accepted) push_expected(data, idx);
    if (model_rem == 0) begin
      if (accepted) model_rem = COL_CYCLES;
    end else if (DOUBLE_BUF && model_rem == 1) begin
      if (model_shadow) begin
        model_rem    = COL_CYCLES;
        model_shadow = 1'b0;
      end else if (accepted) begin
        model_rem = COL_CYCLES;
      end else begin
        model_rem = 0;
      end
    end else begin
      model_rem--;
      if (accepted) model_shadow = 1'b1;
    end
  endtask

  // Monitor: compares each shifted pixel, each latch and each display window.
  always @(negedge clk_in) begin
    if (rst_in) begin
      exp_shift.delete();
      exp_latch.delete();
      exp_hold.delete();
      mon_prev_clk = 1'b0;
      mon_shifts   = 0;
      mon_hold_run = 0;
    end else begin
      if (led_clk && !mon_prev_clk) begin
        mon_shifts++;
        if (exp_shift.size() == 0) flag_event("shift_unexpected");
        else begin
          mon_exp = exp_shift.pop_front();
          check_output("shift_rgb", int'(rgb), int'(mon_exp));
        end
      end
      if (led_latch) begin
        check_output("shifts_per_plane", mon_shifts, NR);
        mon_shifts = 0;
        if (exp_latch.size() == 0) flag_event("latch_unexpected");
        else check_output("latch_row_addr", int'(row_addr), exp_latch.pop_front());
      end
      if (!led_output_enable) begin
        mon_hold_run++;
        if (led_clk || led_latch) flag_event("activity_while_lit");
      end else if (mon_hold_run != 0) begin
        if (exp_hold.size() == 0) flag_event("hold_unexpected");
        else check_output("hold_length", mon_hold_run, exp_hold.pop_front());
        mon_hold_run = 0;
      end
      mon_prev_clk = led_clk;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   acc;
    col_t d;
    logic [AW-1:0] idx;
    int   rel, first_clk, first_latch, first_low, last_low, latches, lows, latch_n;
    int   col_latch[$];

    rst_in = 1'b1;
    tvalid = 1'b0;
    column_data = '0;
    col_index = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_output("reset_tready", int'(tready), 0);
    check_output("reset_rgb", int'(rgb), 0);
    check_output("reset_led_clk", int'(led_clk), 0);
    check_output("reset_latch", int'(led_latch), 0);
    check_output("reset_oe", int'(led_output_enable), 1);
    check_output("reset_row_addr", int'(row_addr), 0);
    rst_in = 1'b0;

    $display("[TB] directed column: R=5 G=0 B=7, col_index=5");
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NR; p++)
        d[c][p] = 9'b111_000_101;
    apply_stimulus(1'b1, d, AW'(5), acc);
    first_clk = -1; first_latch = -1; first_low = -1; last_low = -1;
    rel = 1;
    while (rel <= COL_CYCLES + 20) begin
      if (led_clk && first_clk < 0) first_clk = rel;
      if (led_latch && first_latch < 0) first_latch = rel;
      if (!led_output_enable) begin
        if (first_low < 0) first_low = rel;
        last_low = rel;
      end
      apply_stimulus(1'b0, d, AW'(0), acc);
      rel++;
    end
    check_output("first_led_clk_cycle", first_clk, 2);
    check_output("first_latch_cycle", first_latch, 2 * NR + 1);
    check_output("first_oe_low_cycle", first_low, 2 * NR + 2);
    check_output("column_end_cycle", last_low, COL_CYCLES);

    $display("[TB] reset during plane-1 display");
    apply_stimulus(1'b1, rand_col(), rand_idx(), acc);
    latches = 0;
    rel = 0;
    while (latches < 2 && rel < 3 * COL_CYCLES) begin
      if (led_latch) latches++;
      apply_stimulus(1'b0, d, AW'(0), acc);
      rel++;
    end
    check_output("reached_plane1_latch", latches, 2);
    repeat (20) apply_stimulus(1'b0, d, AW'(0), acc);
    check_output("plane1_lit_before_reset", int'(led_output_enable), 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_rem = 0;
    model_shadow = 1'b0;
    #1;
    check_output("post_reset_oe", int'(led_output_enable), 1);
    check_output("post_reset_rgb", int'(rgb), 0);
    check_output("post_reset_row_addr", int'(row_addr), 0);
    check_output("post_reset_latch", int'(led_latch), 0);
    check_output("post_reset_tready", int'(tready), 1);
    latches = 0;
    lows = 0;
    repeat (COL_CYCLES + 50) begin
      if (led_latch) latches++;
      if (!led_output_enable) lows++;
      apply_stimulus(1'b0, d, AW'(0), acc);
    end
    check_output("latches_after_reset", latches, 0);
    check_output("lit_cycles_after_reset", lows, 0);

    $display("[TB] continuous tvalid, three random columns");
    d = rand_col();
    idx = rand_idx();
    latch_n = 0;
    lows = 0;
    rel = 0;
    while (rel < 4 * (COL_CYCLES + 1) + 50) begin
      if (led_latch) begin
        if (latch_n % CB == 0) col_latch.push_back(rel);
        latch_n++;
      end
      apply_stimulus(lows < 3, d, idx, acc);
      if (acc) begin
        lows++;
        d = rand_col();
        idx = rand_idx();
      end
      rel++;
    end
    check_output("stream_columns_latched", col_latch.size(), 3);
    for (int i = 1; i < col_latch.size(); i++)
      check_output("column_spacing", col_latch[i] - col_latch[i-1],
                   COL_CYCLES + (DOUBLE_BUF ? 0 : 1));

    check_output("scoreboard_drained",
                 exp_shift.size() + exp_latch.size() + exp_hold.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
